// File: rtl/idma_obi_sram_bridge.sv
// OBI subordinate to fixed-latency SRAM bridge: grants bounded by outstanding
// responses, a valid/we pipeline tracking the memory latency, and an FWFT response FIFO.
module idma_obi_sram_bridge #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned RspDepth   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   obi_a_req_i,
    input  logic [AddrWidth-1:0]   obi_a_addr_i,
    input  logic                   obi_a_we_i,
    input  logic [DataWidth/8-1:0] obi_a_be_i,
    input  logic [DataWidth-1:0]   obi_a_wdata_i,
    output logic                   obi_a_gnt_o,
    output logic                   obi_r_valid_o,
    output logic [DataWidth-1:0]   obi_r_rdata_o,
    input  logic                   obi_r_ready_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [CntW-1:0]       cnt_q;
    logic [MemLatency-1:0] pipe_vld_q;
    logic [MemLatency-1:0] pipe_we_q;
    logic [DataWidth-1:0]  fifo_q [RspDepth];
    logic [PtrW-1:0]       wptr_q;
    logic [PtrW-1:0]       rptr_q;
    logic [CntW-1:0]       occ_q;

    logic                  gnt;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic [DataWidth-1:0]  push_data;

    assign gnt         = obi_a_req_i && (cnt_q < CntW'(RspDepth));
    assign obi_a_gnt_o = gnt;
    assign mem_req_o   = gnt;
    assign mem_we_o    = obi_a_we_i;
    assign mem_addr_o  = obi_a_addr_i;
    assign mem_be_o    = obi_a_be_i;
    assign mem_wdata_o = obi_a_wdata_i;

    assign obi_r_valid_o = (occ_q != '0);
    assign obi_r_rdata_o = obi_r_valid_o ? fifo_q[rptr_q] : '0;

    assign pop       = obi_r_valid_o && obi_r_ready_i;
    assign push      = pipe_vld_q[MemLatency-1];
    assign push_data = pipe_we_q[MemLatency-1] ? '0 : mem_rdata_i;
    assign fifo_full = (occ_q == CntW'(RspDepth));

    // Outstanding count covers pipeline plus FIFO, which is what keeps the FIFO from overflowing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            unique case ({gnt, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            pipe_we_q  <= '0;
        end else begin
            pipe_vld_q[0] <= gnt;
            pipe_we_q[0]  <= obi_a_we_i;
            for (int i = 1; i < MemLatency; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_we_q[i]  <= pipe_we_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == PtrW'(RspDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrW'(RspDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + CntW'(1);
                2'b01:   occ_q <= occ_q - CntW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= push_data;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_idma_obi_sram_bridge.sv
// Directed bench for idma_obi_sram_bridge: one instance with default parameters
// and one with MemLatency=3, RspDepth=5, each backed by a fixed-latency memory model.
module tb_idma_obi_sram_bridge;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter instance.
    logic        req1, we1, gnt1, rvalid1, rready1, mreq1, mwe1;
    logic [31:0] addr1, wdata1, rdata1, maddr1, mwdata1, mrdata1;
    logic [3:0]  be1, mbe1;

    // MemLatency=3, RspDepth=5 instance.
    logic        req3, we3, gnt3, rvalid3, rready3, mreq3, mwe3;
    logic [31:0] addr3, wdata3, rdata3, maddr3, mwdata3, mrdata3;
    logic [3:0]  be3, mbe3;

    idma_obi_sram_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .obi_a_req_i(req1), .obi_a_addr_i(addr1), .obi_a_we_i(we1),
        .obi_a_be_i(be1), .obi_a_wdata_i(wdata1), .obi_a_gnt_o(gnt1),
        .obi_r_valid_o(rvalid1), .obi_r_rdata_o(rdata1), .obi_r_ready_i(rready1),
        .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1),
        .mem_be_o(mbe1), .mem_wdata_o(mwdata1), .mem_rdata_i(mrdata1)
    );

    idma_obi_sram_bridge #(.MemLatency(3), .RspDepth(5)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .obi_a_req_i(req3), .obi_a_addr_i(addr3), .obi_a_we_i(we3),
        .obi_a_be_i(be3), .obi_a_wdata_i(wdata3), .obi_a_gnt_o(gnt3),
        .obi_r_valid_o(rvalid3), .obi_r_rdata_o(rdata3), .obi_r_ready_i(rready3),
        .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3),
        .mem_be_o(mbe3), .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3)
    );

    // Read-only memory image; returns a nonzero word on every cycle so write responses expose leaks.
    function automatic logic [31:0] mem_word(input logic [7:0] idx);
        return (idx == 8'd64) ? 32'hDEADBEEF : {24'hC0DE00, idx};
    endfunction

    logic [31:0] rd1_q;
    logic [31:0] rd3_q [3];
    always @(posedge clk_i) begin
        rd1_q    <= mem_word(maddr1[9:2]);
        rd3_q[0] <= mem_word(maddr3[9:2]);
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign mrdata1 = rd1_q;
    assign mrdata3 = rd3_q[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive the default instance just after a rising edge, then wait for the sampling edge.
    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic rdy);
        req1 = req; we1 = we; addr1 = addr; be1 = be; wdata1 = wd; rready1 = rdy;
        @(negedge clk_i);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = '0; be1 = 4'hF; wdata1 = '0; rready1 = 1'b1;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = 4'hF; wdata3 = '0; rready3 = 1'b1;

        // Reset state: no response, grant follows request.
        @(negedge clk_i);
        check("rst_rvalid", 32'(rvalid1), 32'd0);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_gnt", 32'(gnt1), 32'd1);
        check("rst_mreq", 32'(mreq1), 32'd1);
        req1 = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Single read at 0x100.
        drive(1'b1, 1'b0, 32'h100, 4'hF, '0, 1'b1);
        check("rd_gnt", 32'(gnt1), 32'd1);
        check("rd_mreq", 32'(mreq1), 32'd1);
        check("rd_maddr", maddr1, 32'h100);
        check("rd_rvalid_t0", 32'(rvalid1), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("rd_rvalid_t1", 32'(rvalid1), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("rd_rvalid_t2", 32'(rvalid1), 32'd1);
        check("rd_rdata_t2", rdata1, 32'hDEADBEEF);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("rd_rvalid_t3", 32'(rvalid1), 32'd0);
        check("rd_cnt_t3", 32'(dut.cnt_q), 32'd0);
        next_cycle();

        // Sixteen back-to-back reads with ready held high.
        for (int k = 0; k < 19; k++) begin
            drive(k < 16, 1'b0, 32'(4 * k), 4'hF, '0, 1'b1);
            if (k < 16) check($sformatf("str_gnt%0d", k), 32'(gnt1), 32'd1);
            check($sformatf("str_rvalid%0d", k), 32'(rvalid1), 32'((k >= 2) && (k < 18)));
            if ((k >= 2) && (k < 18))
                check($sformatf("str_rdata%0d", k), rdata1, {24'hC0DE00, 8'(k - 2)});
            next_cycle();
        end

        // Backpressure: three grants, stall, then drain in order and resume.
        for (int k = 0; k < 11; k++) begin
            drive(k <= 7, 1'b0, 32'h10 + 32'(4 * ((k < 3) ? k : 3)), 4'hF, '0, k >= 6);
            check($sformatf("bp_gnt%0d", k), 32'(gnt1), 32'((k < 3) || (k == 7)));
            check($sformatf("bp_rvalid%0d", k), 32'(rvalid1), 32'((k >= 2) && (k <= 9)));
            if ((k >= 2) && (k <= 9))
                check($sformatf("bp_rdata%0d", k), rdata1, {24'hC0DE00, 8'((k <= 6) ? 4 : k - 2)});
            next_cycle();
        end

        // Write returns an all-zero response two cycles after the grant.
        drive(1'b1, 1'b1, 32'h20, 4'b0011, 32'h12345678, 1'b1);
        check("wr_gnt", 32'(gnt1), 32'd1);
        check("wr_mwe", 32'(mwe1), 32'd1);
        check("wr_mbe", 32'(mbe1), 32'h3);
        check("wr_mwdata", mwdata1, 32'h12345678);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("wr_rvalid_t1", 32'(rvalid1), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("wr_rvalid_t2", 32'(rvalid1), 32'd1);
        check("wr_rdata_t2", rdata1, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
        check("wr_rvalid_t3", 32'(rvalid1), 32'd0);
        next_cycle();

        // Reset with two responses buffered and one in the pipeline.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h30 + 32'(4 * k), 4'hF, '0, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b0);
        check("mr_rvalid_pre", 32'(rvalid1), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mr_rvalid_rst", 32'(rvalid1), 32'd0);
        check("mr_cnt_rst", 32'(dut.cnt_q), 32'd0);
        req1 = 1'b1;
        #1;
        check("mr_gnt_rst", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, '0, 4'hF, '0, 1'b1);
            check($sformatf("mr_stale%0d", k), 32'(rvalid1), 32'd0);
            next_cycle();
        end
        check("mr_cnt_post", 32'(dut.cnt_q), 32'd0);

        // MemLatency=3: read / write / read, responses at grant+4.
        for (int k = 0; k < 8; k++) begin
            req3 = (k < 3); we3 = (k == 1);
            addr3 = (k == 0) ? 32'h08 : (k == 1) ? 32'h40 : 32'h0C;
            wdata3 = 32'hCAFEF00D; rready3 = 1'b1;
            @(negedge clk_i);
            check($sformatf("l3_gnt%0d", k), 32'(gnt3), 32'(k < 3));
            check($sformatf("l3_rvalid%0d", k), 32'(rvalid3), 32'((k >= 4) && (k <= 6)));
            if (k == 4) check("l3_rdata_rd0", rdata3, 32'hC0DE0002);
            if (k == 5) check("l3_rdata_wr", rdata3, 32'h0);
            if (k == 6) check("l3_rdata_rd1", rdata3, 32'hC0DE0003);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/idma_obi_sram_bridge.md
IDMA_OBI_SRAM_BRIDGE -- requirements
Module: idma_obi_sram_bridge

Interface
REQ-001 Parameter DataWidth, default 32: OBI and memory data width in bits; a multiple of 8.
REQ-002 Parameter AddrWidth, default 32: byte address width.
REQ-003 Parameter MemLatency, default 1: fixed memory read latency in cycles; legal range 1..4.
REQ-004 Parameter RspDepth, default 3: maximum number of outstanding responses; legal minimum 2.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 obi_a_req_i  input  1  OBI A-channel request valid.
REQ-008 obi_a_addr_i  input  AddrWidth  byte address.
REQ-009 obi_a_we_i  input  1  1 = write, 0 = read.
REQ-010 obi_a_be_i  input  DataWidth/8  byte enables.
REQ-011 obi_a_wdata_i  input  DataWidth  write data.
REQ-012 obi_a_gnt_o  output  1  A-channel grant.
REQ-013 obi_r_valid_o  output  1  R-channel response valid.
REQ-014 obi_r_rdata_o  output  DataWidth  response data.
REQ-015 obi_r_ready_i  input  1  R-channel ready from the iDMA OBI backend.
REQ-016 mem_req_o  output  1  memory access strobe.
REQ-017 mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o  outputs  1/AddrWidth/DataWidth/8/DataWidth  access attributes, each a combinational pass-through of the matching A-channel input.
REQ-018 mem_rdata_i  input  DataWidth  read data, valid exactly MemLatency cycles after the mem_req_o cycle.

Function
REQ-019 Outstanding counter cnt, width $clog2(RspDepth+1):
  - increments at the end of every grant cycle;
  - decrements at the end of every cycle with obi_r_valid_o && obi_r_ready_i;
  - is unchanged when a grant and a pop happen in the same cycle.
REQ-020 obi_a_gnt_o = obi_a_req_i && (cnt < RspDepth). It has no combinational dependence on obi_r_ready_i.
REQ-021 mem_req_o = obi_a_gnt_o: a memory access occurs only in a grant cycle.
REQ-022 A MemLatency-stage shift register carries {valid, we} per granted access. Stage 0 is loaded at the end of the grant cycle.
REQ-023 When the final stage is valid, the response FIFO is pushed at the end of that cycle:
  - mem_rdata_i is pushed for reads;
  - all-zero data is pushed for writes.
REQ-024 The response FIFO has depth RspDepth and is first-word-fall-through. obi_r_valid_o = FIFO not empty; obi_r_rdata_o = FIFO head.
REQ-025 The FIFO never overflows, because cnt bounds pipeline plus FIFO occupancy. A push into a full FIFO is an assertion error.
REQ-026 Latency: a request granted in cycle t shows obi_r_valid_o in cycle t+MemLatency+1 at the earliest.
REQ-027 Responses are returned strictly in grant order.
REQ-028 Throughput: with RspDepth >= MemLatency+2 and obi_r_ready_i held high, one grant per cycle is sustained indefinitely.
REQ-029 Backpressure: while obi_r_ready_i is low, the following hold their values:
  - obi_r_valid_o and obi_r_rdata_o;
  - obi_a_gnt_o drops once cnt reaches RspDepth.
REQ-030 Push and pop of the FIFO in the same cycle are both honoured. Occupancy is unchanged and order is preserved.
REQ-031 The block has no state machine beyond the counter, the pipeline and the FIFO. It never drops or duplicates a response.

Reset
REQ-032 Asynchronous reset assertion clears cnt, all pipeline valid bits, and the FIFO pointers and occupancy.
REQ-033 During and after reset:
  - obi_r_valid_o = 0;
  - obi_r_rdata_o = 0 (FIFO storage data is don't-care);
  - obi_a_gnt_o and mem_req_o follow obi_a_req_i (cnt = 0).
REQ-034 Reset mid-operation discards all in-flight accesses and buffered responses. No response for them appears after reset deassertion.

Verification
REQ-035 Single read, MemLatency=1: req at t, addr 0x100, mem returns 0xDEADBEEF at t+1 -> gnt at t, r_valid at t+2 with rdata 0xDEADBEEF, cnt back to 0 at t+3.
REQ-036 Streaming, MemLatency=1, RspDepth=3, r_ready=1: 16 back-to-back reads -> 16 consecutive grants, r_valid continuous from t+2 for 16 cycles, data in order.
REQ-037 Backpressure, RspDepth=3: r_ready=0, req held high -> exactly 3 grants, then gnt=0. Raising r_ready -> 3 responses in order, then grants resume.
REQ-038 Write, be=4'b0011, wdata 0x12345678 -> mem_we_o=1, mem_be_o=0011 at grant; r_valid two cycles later with rdata 0x00000000.
REQ-039 MemLatency=3, RspDepth=5: interleaved read/write/read -> responses in order at grant+4; read data correct; write data zero.
REQ-040 Reset asserted with 2 responses buffered and 1 in pipeline -> r_valid=0 immediately. After deassertion there are no stale responses and cnt=0.
